// File: rtl/pipe_stall_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | pipe_stall_ctrl: pipeline stall vector and multi-cycle divide FSM     |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module pipe_stall_ctrl #(
   parameter logic [7:0] DIV_OP      = 8'h16,
   parameter logic [7:0] DIVU_OP     = 8'h17,
   parameter int         DIV_TIMEOUT = 40
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       stallreq_id,
   input  logic [7:0] exe_aluop,
   input  logic       div_ready,
   input  logic       flush,
   output logic [3:0] stall,
   output logic       div_start,
   output logic       div_signed,
   output logic       div_abort,
   output logic       div_timeout,
   output logic       div_busy
);

   localparam logic [1:0] c_st_idle  = 2'b00;
   localparam logic [1:0] c_st_busy  = 2'b01;
   localparam logic [1:0] c_st_done  = 2'b10;
   localparam logic [7:0] c_cnt_last = 8'(DIV_TIMEOUT - 1);

   logic [1:0] r_state;
   logic [1:0] w_state_nxt;
   logic [7:0] r_cnt;
   logic [7:0] w_cnt_nxt;
   logic       r_timeout;
   logic       w_timeout_nxt;
   logic       w_is_div;

   assign w_is_div = (exe_aluop == DIV_OP) || (exe_aluop == DIVU_OP);

   always_comb begin
      w_state_nxt   = r_state;
      w_cnt_nxt     = r_cnt;
      w_timeout_nxt = r_timeout;
      stall         = 4'b0000;
      div_start     = 1'b0;
      div_abort     = 1'b0;
      case (r_state)
         c_st_idle: begin
            if (flush) begin
               stall = 4'b0000;
            end else if (w_is_div) begin
               stall       = 4'b1111;
               div_start   = 1'b1;
               w_cnt_nxt   = 8'd0;
               w_state_nxt = c_st_busy;
            end else if (stallreq_id) begin
               stall = 4'b0111;
            end
         end
         c_st_busy: begin
            if (flush) begin
               div_abort   = 1'b1;
               w_state_nxt = c_st_idle;
            end else begin
               stall     = 4'b1111;
               w_cnt_nxt = r_cnt + 8'd1;
               if (div_ready) begin
                  w_state_nxt = c_st_done;
               end else if (r_cnt == c_cnt_last) begin
                  w_timeout_nxt = 1'b1;
                  w_state_nxt   = c_st_done;
               end
            end
         end
         // DONE releases the pipeline for one cycle and never restarts.
         c_st_done: w_state_nxt = c_st_idle;
         default:   w_state_nxt = c_st_idle;
      endcase
      // Outputs stay quiet while reset is held, regardless of inputs.
      if (!rst_n) begin
         stall     = 4'b0000;
         div_start = 1'b0;
         div_abort = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= c_st_idle;
         r_cnt     <= 8'd0;
         r_timeout <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_cnt     <= w_cnt_nxt;
         r_timeout <= w_timeout_nxt;
      end
   end

   assign div_signed  = (exe_aluop == DIV_OP);
   assign div_busy    = (r_state == c_st_busy);
   assign div_timeout = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_pipe_stall_ctrl.sv
`default_nettype none
// Directed scoreboard bench for pipe_stall_ctrl.
module tb_pipe_stall_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       stallreq_id = 1'b0;
   logic [7:0] exe_aluop = 8'h00;
   logic       div_ready = 1'b0;
   logic       flush = 1'b0;
   logic [3:0] stall;
   logic       div_start;
   logic       div_signed;
   logic       div_abort;
   logic       div_timeout;
   logic       div_busy;

   typedef struct packed {
      logic [3:0] stall;
      logic       start;
      logic       sgn;
      logic       abort;
      logic       to;
      logic       busy;
   } exp_t;

   exp_t exp_q[$];
   int   n_assert = 0;
   int   n_fail = 0;
   logic to_exp = 1'b0;

   pipe_stall_ctrl #(
      .DIV_OP      (8'h16),
      .DIVU_OP     (8'h17),
      .DIV_TIMEOUT (40)
   ) u_dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .stallreq_id (stallreq_id),
      .exe_aluop   (exe_aluop),
      .div_ready   (div_ready),
      .flush       (flush),
      .stall       (stall),
      .div_start   (div_start),
      .div_signed  (div_signed),
      .div_abort   (div_abort),
      .div_timeout (div_timeout),
      .div_busy    (div_busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   // One clock cycle: drive at negedge, queue expectation, compare 1 ns later.
   task automatic step(input string tag, input logic rst, input logic sid,
                       input logic [7:0] op, input logic rdy, input logic fl,
                       input logic [3:0] e_stall, input logic e_start,
                       input logic e_abort, input logic e_busy);
      exp_t e;
      exp_t got;
      @(negedge clk);
      rst_n       = rst;
      stallreq_id = sid;
      exe_aluop   = op;
      div_ready   = rdy;
      flush       = fl;
      e.stall = e_stall;
      e.start = e_start;
      e.sgn   = (op == 8'h16);
      e.abort = e_abort;
      e.to    = to_exp;
      e.busy  = e_busy;
      exp_q.push_back(e);
      #1;
      got = exp_q.pop_front();
      check({tag, ".stall"}, stall, got.stall);
      check({tag, ".start"}, {3'b000, div_start}, {3'b000, got.start});
      check({tag, ".signed"}, {3'b000, div_signed}, {3'b000, got.sgn});
      check({tag, ".abort"}, {3'b000, div_abort}, {3'b000, got.abort});
      check({tag, ".timeout"}, {3'b000, div_timeout}, {3'b000, got.to});
      check({tag, ".busy"}, {3'b000, div_busy}, {3'b000, got.busy});
   endtask

   initial begin
      // Reset held with active requests present: everything quiet
      step("rst_a", 1'b0, 1'b1, 8'h16, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0);
      step("rst_b", 1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0);

      // Signed divide, ready on 5th BUSY cycle
      step("a_c0", 1'b1, 1'b0, 8'h16, 1'b0, 1'b0, 4'b1111, 1'b1, 1'b0, 1'b0);
      step("a_c1", 1'b1, 1'b0, 8'h16, 1'b0, 1'b0, 4'b1111, 1'b0, 1'b0, 1'b1);
      step("a_c2", 1'b1, 1'b1, 8'h16, 1'b0, 1'b0, 4'b1111, 1'b0, 1'b0, 1'b1);
      step("a_c3", 1'b1, 1'b0, 8'h16, 1'b0, 1'b0, 4'b1111, 1'b0, 1'b0, 1'b1);
      step("a_c4", 1'b1, 1'b0, 8'h16, 1'b0, 1'b0, 4'b1111, 1'b0, 1'b0, 1'b1);
      step("a_c5", 1'b1, 1'b0, 8'h16, 1'b1, 1'b0, 4'b1111, 1'b0, 1'b0, 1'b1);
      step("a_done", 1'b1, 1'b0, 8'h16, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0);
      step("a_idle", 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0);

      // Load-use stall, then unsigned divide overrides it, flush on 3rd BUSY
      step("b_ld", 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 4'b0111, 1'b0, 1'b0, 1'b0);
      step("b_divu", 1'b1, 1'b1, 8'h17, 1'b0, 1'b0, 4'b1111, 1'b1, 1'b0, 1'b0);
      step("b_busy1", 1'b1, 1'b1, 8'h17, 1'b0, 1'b0, 4'b1111, 1'b0, 1'b0, 1'b1);
      step("b_busy2", 1'b1, 1'b1, 8'h17, 1'b0, 1'b0, 4'b1111, 1'b0, 1'b0, 1'b1);
      step("b_flush", 1'b1, 1'b1, 8'h17, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b1, 1'b1);
      step("b_idle", 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0);

      // Flush beats divide in IDLE; stray ready in IDLE ignored
      step("c_fl_idle", 1'b1, 1'b1, 8'h16, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0);
      step("c_rdy_idle", 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0);
      step("c_after", 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 4'b0111, 1'b0, 1'b0, 1'b0);

      // Back-to-back divides, flush in DONE
      step("d_start1", 1'b1, 1'b0, 8'h16, 1'b0, 1'b0, 4'b1111, 1'b1, 1'b0, 1'b0);
      step("d_busy1", 1'b1, 1'b0, 8'h16, 1'b1, 1'b0, 4'b1111, 1'b0, 1'b0, 1'b1);
      step("d_done1", 1'b1, 1'b0, 8'h16, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0);
      step("d_start2", 1'b1, 1'b0, 8'h16, 1'b0, 1'b0, 4'b1111, 1'b1, 1'b0, 1'b0);
      step("d_busy2", 1'b1, 1'b0, 8'h16, 1'b1, 1'b0, 4'b1111, 1'b0, 1'b0, 1'b1);
      step("d_done_fl", 1'b1, 1'b0, 8'h16, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0);
      step("d_idle", 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0);

      // Watchdog: 40 BUSY cycles without ready
      step("t_start", 1'b1, 1'b0, 8'h17, 1'b0, 1'b0, 4'b1111, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 40; i++) begin
         step($sformatf("t_busy%0d", i), 1'b1, 1'b0, 8'h00, 1'b0, 1'b0,
              4'b1111, 1'b0, 1'b0, 1'b1);
      end
      to_exp = 1'b1;
      step("t_done", 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0);
      step("t_idle", 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0);

      // Abort after timeout keeps the sticky flag
      step("f_start", 1'b1, 1'b0, 8'h16, 1'b0, 1'b0, 4'b1111, 1'b1, 1'b0, 1'b0);
      step("f_busy", 1'b1, 1'b0, 8'h16, 1'b0, 1'b0, 4'b1111, 1'b0, 1'b0, 1'b1);
      step("f_flush", 1'b1, 1'b0, 8'h16, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b1, 1'b1);
      step("f_idle", 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0);

      // Reset dropped mid-BUSY
      step("r_start", 1'b1, 1'b0, 8'h17, 1'b0, 1'b0, 4'b1111, 1'b1, 1'b0, 1'b0);
      step("r_busy", 1'b1, 1'b0, 8'h17, 1'b0, 1'b0, 4'b1111, 1'b0, 1'b0, 1'b1);
      to_exp = 1'b0;
      step("r_rst", 1'b0, 1'b1, 8'h17, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0);
      step("r_rel", 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0);
      step("r_new", 1'b1, 1'b0, 8'h16, 1'b0, 1'b0, 4'b1111, 1'b1, 1'b0, 1'b0);
      step("r_busy2", 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 4'b1111, 1'b0, 1'b0, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
